// File: rtl/pfb_pkg.sv
// Shared types and helpers for the channelizer PFB front end.
// The beat struct is also used by the PFB-side FIFO.
package pfb_pkg;

    localparam int PFB_MAX_PHASES  = 128;
    localparam int PFB_DATA_WIDTH  = 32;
    localparam int PFB_PHASE_WIDTH = 7;

    typedef struct packed {
        logic [PFB_DATA_WIDTH-1:0]  data;
        logic [PFB_PHASE_WIDTH-1:0] phase;
        logic                       last;
    } pfb_beat_t;

    // Legal revolution lengths are 2..PFB_MAX_PHASES; anything outside is pinned to the nearest end.
    function automatic logic [7:0] clamp_phases(input logic [7:0] requested);
        if (requested < 8'd2)
            return 8'd2;
        if (requested > 8'(PFB_MAX_PHASES))
            return 8'(PFB_MAX_PHASES);
        return requested;
    endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Generic 2-entry AXI-Stream register slice: a main output register plus one skid register.
// in_ready comes straight from a flop, so no combinational path runs from out_ready to in_ready.
module axis_skid_buf
    import pfb_pkg::*;
#(
    parameter int WIDTH = $bits(pfb_beat_t)
) (
    input  logic             clk,
    input  logic             sync_reset_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;
    logic             in_fire;

    assign in_ready = ~skid_valid;
    assign in_fire  = in_valid & in_ready;

    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!sync_reset_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
        end else if (!out_valid || out_ready) begin
            // The output register is free: the skid entry is older, so it drains first.
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_data   <= skid_data;
                skid_valid <= 1'b0;
            end else begin
                out_valid <= in_fire;
                if (in_fire)
                    out_data <= in_data;
            end
        end else if (in_fire) begin
            skid_valid <= 1'b1;
        end
    end

    // NOTE: skid_data needs no reset; it is only read while skid_valid is set, and in_fire
    // implies the skid is empty, so this load never overwrites a live entry.
    always_ff @(posedge clk) begin
        if (in_fire)
            skid_data <= in_data;
    end

endmodule

// File: rtl/pfb_commutator_128mmax.sv
// Input-side commutator for the M-path PFB: tags each sample with its arm index (descending M-1..0)
// and marks arm 0 as tlast. The revolution length M changes only at frame boundaries or on resync.
module pfb_commutator_128mmax
    import pfb_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int PHASE_WIDTH = 7
) (
    input  logic                   clk,
    input  logic                   sync_reset_n,
    input  logic [7:0]             num_phases,
    input  logic                   resync,
    input  logic                   s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
    output logic                   s_axis_tready,
    output logic                   m_axis_tvalid,
    output logic [DATA_WIDTH-1:0]  m_axis_tdata,
    output logic [PHASE_WIDTH-1:0] phase,
    output logic                   m_axis_tlast,
    input  logic                   m_axis_tready,
    output logic [7:0]             active_phases
);

    localparam int BEAT_WIDTH = DATA_WIDTH + PHASE_WIDTH + 1;

    logic [7:0]             req_phases;
    logic [PHASE_WIDTH-1:0] req_top_phase;
    logic [PHASE_WIDTH-1:0] phase_cnt;
    logic [PHASE_WIDTH-1:0] cur_phase;
    logic                   cur_last;
    logic                   resync_pend;
    logic                   in_fire;
    logic [BEAT_WIDTH-1:0]  in_beat;
    logic [BEAT_WIDTH-1:0]  out_beat;

    assign req_phases    = clamp_phases(num_phases);
    assign req_top_phase = PHASE_WIDTH'(req_phases - 8'd1);
    assign in_fire       = s_axis_tvalid & s_axis_tready;

    // NOTE: every signal driven in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        cur_phase = phase_cnt;
        if (resync_pend)
            cur_phase = req_top_phase;
        cur_last = (cur_phase == '0);
    end

    always_ff @(posedge clk) begin
        if (!sync_reset_n) begin
            active_phases <= req_phases;
            phase_cnt     <= req_top_phase;
            resync_pend   <= 1'b0;
        end else begin
            // A resync arriving alongside an accepted beat applies to the beat after it.
            resync_pend <= resync | (resync_pend & ~in_fire);
            if (in_fire) begin
                if (cur_last) begin
                    active_phases <= req_phases;
                    phase_cnt     <= req_top_phase;
                end else begin
                    phase_cnt <= cur_phase - PHASE_WIDTH'(1);
                    if (resync_pend)
                        active_phases <= req_phases;
                end
            end
        end
    end

    assign in_beat = {s_axis_tdata, cur_phase, cur_last};

    axis_skid_buf #(
        .WIDTH (BEAT_WIDTH)
    ) u_skid (
        .clk          (clk),
        .sync_reset_n (sync_reset_n),
        .in_valid     (s_axis_tvalid),
        .in_data      (in_beat),
        .in_ready     (s_axis_tready),
        .out_valid    (m_axis_tvalid),
        .out_data     (out_beat),
        .out_ready    (m_axis_tready)
    );

    assign {m_axis_tdata, phase, m_axis_tlast} = out_beat;

endmodule

// File: tb/tb_pfb_commutator_128mmax.sv
// Directed bench for pfb_commutator_128mmax: a reference model fills a scoreboard at input
// acceptance, output beats are popped and compared, and each sequence is also checked in closed form.
`timescale 1ns/1ps
module tb_pfb_commutator_128mmax;
    import pfb_pkg::*;

    logic        clk = 1'b0;
    logic        sync_reset_n;
    logic [7:0]  num_phases;
    logic        resync;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_ready;
    logic        m_valid;
    logic [31:0] m_data;
    logic [6:0]  phase;
    logic        m_last;
    logic        m_ready;
    logic [7:0]  active;

    always #5 clk = ~clk;

    pfb_commutator_128mmax dut (
        .clk           (clk),
        .sync_reset_n  (sync_reset_n),
        .num_phases    (num_phases),
        .resync        (resync),
        .s_axis_tvalid (s_valid),
        .s_axis_tdata  (s_data),
        .s_axis_tready (s_ready),
        .m_axis_tvalid (m_valid),
        .m_axis_tdata  (m_data),
        .phase         (phase),
        .m_axis_tlast  (m_last),
        .m_axis_tready (m_ready),
        .active_phases (active)
    );

    int        n_checks = 0;
    int        n_fail   = 0;
    int        cyc      = 0;
    bit        rand_ready = 1'b0;
    pfb_beat_t sb[$];
    pfb_beat_t obs[$];
    int        exp_ph[$];

    int        mdl_m;
    int        mdl_cnt;
    bit        mdl_pend;
    bit        held;
    pfb_beat_t held_beat;

    function automatic int ref_clamp(input int n);
        if (n < 2)   return 2;
        if (n > 128) return 128;
        return n;
    endfunction

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Monitor: samples on the falling edge and predicts what the next rising edge commits.
    always @(negedge clk) begin
        pfb_beat_t got;
        pfb_beat_t exp_b;
        int        cur;
        cyc++;
        if (!sync_reset_n) begin
            sb.delete();
            held     = 1'b0;
            mdl_m    = ref_clamp(int'(num_phases));
            mdl_cnt  = mdl_m - 1;
            mdl_pend = 1'b0;
        end else begin
            chk("active_phases", active, mdl_m);
            got = '{data: m_data, phase: phase, last: m_last};
            if (held) begin
                chk("stall_valid_held", m_valid, 1);
                if (m_valid)
                    chk("stall_beat_stable", got, held_beat);
            end
            held      = m_valid && !m_ready;
            held_beat = got;
            if (m_valid && m_ready) begin
                obs.push_back(got);
                chk("beat_expected", (sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    exp_b = sb.pop_front();
                    chk("beat", got, exp_b);
                end
            end
            if (s_valid && s_ready) begin
                if (mdl_pend) begin
                    mdl_m = ref_clamp(int'(num_phases));
                    cur   = mdl_m - 1;
                end else begin
                    cur = mdl_cnt;
                end
                sb.push_back('{data: s_data, phase: 7'(cur), last: (cur == 0)});
                if (cur == 0) begin
                    mdl_m   = ref_clamp(int'(num_phases));
                    mdl_cnt = mdl_m - 1;
                end else begin
                    mdl_cnt = cur - 1;
                end
                mdl_pend = resync;
            end else begin
                mdl_pend = mdl_pend | resync;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready)
            m_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [31:0] d, input bit r = 1'b0);
        bit acc;
        int guard;
        guard   = 0;
        s_valid = 1'b1;
        s_data  = d;
        resync  = r;
        do begin
            @(negedge clk);
            acc = s_ready;
            tick();
            resync = 1'b0;
            guard++;
        end while (!acc && guard < 1000);
        if (!acc)
            chk("send_timeout", acc, 1);
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic drain();
        int guard;
        guard   = 0;
        s_valid = 1'b0;
        while ((sb.size() != 0 || m_valid) && guard < 2000) begin
            tick();
            guard++;
        end
        chk("drain_remaining", sb.size(), 0);
    endtask

    task automatic do_reset(input logic [7:0] n);
        num_phases   = n;
        s_valid      = 1'b0;
        sync_reset_n = 1'b0;
        tick();
        sync_reset_n = 1'b1;
        tick();
        obs.delete();
        exp_ph.delete();
    endtask

    task automatic add_desc(input int hi, input int lo);
        for (int p = hi; p >= lo; p--)
            exp_ph.push_back(p);
    endtask

    task automatic check_obs(input string tag, input logic [31:0] base);
        chk({tag, "_count"}, obs.size(), exp_ph.size());
        for (int i = 0; i < exp_ph.size() && i < obs.size(); i++) begin
            chk({tag, "_phase"}, obs[i].phase, exp_ph[i]);
            chk({tag, "_last"},  obs[i].last,  (exp_ph[i] == 0));
            chk({tag, "_data"},  obs[i].data,  base + 32'(i));
        end
    endtask

    initial begin
        int c0;
        sync_reset_n = 1'b0;
        num_phases   = 8'd8;
        resync       = 1'b0;
        s_valid      = 1'b0;
        s_data       = '0;
        m_ready      = 1'b1;

        // Reset values on the first cycle after release.
        repeat (3) tick();
        sync_reset_n = 1'b1;
        tick();
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last",  m_last,  0);
        chk("rst_m_data",  m_data,  0);
        chk("rst_phase",   phase,   0);
        chk("rst_s_ready", s_ready, 1);
        chk("rst_active",  active,  8);

        // Continuous stream, M=8: latency and throughput.
        do_reset(8'd8);
        c0 = cyc;
        send(32'h1000);
        chk("latency_valid", m_valid, 1);
        chk("latency_data",  m_data,  32'h1000);
        chk("latency_phase", phase,   7);
        for (int i = 1; i < 1024; i++)
            send(32'h1000 + 32'(i));
        chk("throughput_cycles", cyc - c0, 1024);
        drain();
        repeat (128) add_desc(7, 0);
        check_obs("stream8", 32'h1000);

        // Random valid/ready, M=128.
        do_reset(8'd128);
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 1) == 1)
                idle(1);
            send(32'h2000 + 32'(i));
        end
        drain();
        rand_ready = 1'b0;
        m_ready    = 1'b1;
        add_desc(127, 0);
        add_desc(127, 0);
        add_desc(127, 84);
        check_obs("random128", 32'h2000);

        // M change 16 -> 4 requested mid-revolution takes effect after phase 0.
        do_reset(8'd16);
        for (int i = 0; i < 6; i++)
            send(32'h3000 + 32'(i));
        num_phases = 8'd4;
        for (int i = 6; i < 15; i++)
            send(32'h3000 + 32'(i));
        chk("mchange_active_mid", active, 16);
        for (int i = 15; i < 24; i++)
            send(32'h3000 + 32'(i));
        drain();
        chk("mchange_active_end", active, 4);
        add_desc(15, 0);
        add_desc(3, 0);
        add_desc(3, 0);
        check_obs("mchange", 32'h3000);

        // Resync: standalone pulse after phase 5, then a pulse coinciding with an acceptance.
        do_reset(8'd8);
        for (int i = 0; i < 3; i++)
            send(32'h4000 + 32'(i));
        s_valid = 1'b0;
        resync  = 1'b1;
        tick();
        resync = 1'b0;
        for (int i = 3; i < 13; i++)
            send(32'h4000 + 32'(i));
        send(32'h4000 + 32'd13, 1'b1);
        send(32'h4000 + 32'd14);
        drain();
        add_desc(7, 5);
        add_desc(7, 0);
        add_desc(7, 5);
        add_desc(7, 7);
        check_obs("resync", 32'h4000);

        // Clamping at both ends.
        do_reset(8'd0);
        chk("clamp_low_active", active, 2);
        for (int i = 0; i < 4; i++)
            send(32'h5000 + 32'(i));
        drain();
        add_desc(1, 0);
        add_desc(1, 0);
        check_obs("clamp_low", 32'h5000);

        do_reset(8'd200);
        chk("clamp_high_active", active, 128);
        for (int i = 0; i < 130; i++)
            send(32'h5100 + 32'(i));
        drain();
        add_desc(127, 0);
        add_desc(127, 126);
        check_obs("clamp_high", 32'h5100);

        // One-cycle reset with the skid register occupied.
        do_reset(8'd8);
        m_ready = 1'b0;
        send(32'h6000);
        send(32'h6001);
        s_valid = 1'b0;
        chk("skid_full_ready", s_ready, 0);
        chk("skid_full_valid", m_valid, 1);
        sync_reset_n = 1'b0;
        tick();
        chk("midrst_m_valid", m_valid, 0);
        chk("midrst_m_last",  m_last,  0);
        chk("midrst_m_data",  m_data,  0);
        chk("midrst_phase",   phase,   0);
        chk("midrst_s_ready", s_ready, 1);
        sync_reset_n = 1'b1;
        m_ready      = 1'b1;
        tick();
        obs.delete();
        exp_ph.delete();
        send(32'h6100);
        drain();
        add_desc(7, 7);
        check_obs("post_reset", 32'h6100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
